// File: rtl/mips_boot_sequencer_if.sv
// Bus bundle between the boot sequencer and its neighbours: program stream, instruction-memory
// and register-file ports, core control and the register-dump stream.
interface mips_boot_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned REG_AW = 5
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              reg_we;
    logic [REG_AW-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [REG_AW-1:0] reg_raddr;
    logic [DATA_W-1:0] reg_rdata;
    logic              core_clear;
    logic              core_run;
    logic              core_halted;
    logic              d_valid;
    logic              d_ready;
    logic [REG_AW-1:0] d_idx;
    logic [DATA_W-1:0] d_data;

    modport master (
        input  s_valid, s_data, reg_rdata, core_halted, d_ready,
        output s_ready, mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata, reg_raddr,
               core_clear, core_run, d_valid, d_idx, d_data
    );

    modport slave (
        output s_valid, s_data, reg_rdata, core_halted, d_ready,
        input  s_ready, mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata, reg_raddr,
               core_clear, core_run, d_valid, d_idx, d_data
    );
endinterface

// File: rtl/mips_boot_sequencer.sv
// Core bring-up sequencer: register-file init, program load, clear/run with watchdog,
// then a register dump over a valid/ready stream.
module mips_boot_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DUMP_N = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W:0]      prog_len,
    input  logic [CNT_W-1:0]     timeout,
    mips_boot_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     run_cycles
);
    typedef enum logic [3:0] {
        StIdle, StInit, StLoad, StClear, StRun, StDumpRd, StDumpOut, StDone, StError
    } state_e;

    localparam logic [ADDR_W:0]   MemLen   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [REG_AW-1:0] RegLast  = {REG_AW{1'b1}};
    localparam logic [REG_AW-1:0] DumpLast = REG_AW'(DUMP_N - 1);

    state_e            state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;
    logic [CNT_W-1:0]  tmo_q;
    logic              s_ready_q;
    logic              reg_we_q;
    logic [REG_AW-1:0] reg_addr_q;
    logic              core_clear_q;
    logic              core_run_q;
    logic [REG_AW-1:0] raddr_q;
    logic              d_valid_q;
    logic              d_first_q;
    logic [REG_AW-1:0] d_idx_q;
    logic [DATA_W-1:0] d_data_q;

    logic              beat;
    logic [ADDR_W:0]   cnt_inc;
    logic [CNT_W-1:0]  run_inc;
    logic [ADDR_W:0]   len_clamp;

    assign beat      = s_ready_q & bus.s_valid;
    assign cnt_inc   = cnt_q + (ADDR_W + 1)'(1);
    assign run_inc   = (&run_cycles) ? run_cycles : run_cycles + CNT_W'(1);
    assign len_clamp = (prog_len > MemLen) ? MemLen : prog_len;

    assign bus.s_ready    = s_ready_q;
    assign bus.mem_we     = beat;
    assign bus.mem_addr   = cnt_q[ADDR_W-1:0];
    assign bus.mem_wdata  = s_ready_q ? bus.s_data : '0;
    assign bus.reg_we     = reg_we_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_wdata  = DATA_W'(reg_addr_q);
    assign bus.reg_raddr  = raddr_q;
    assign bus.core_clear = core_clear_q;
    assign bus.core_run   = core_run_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.d_idx      = d_idx_q;
    // First DUMP_OUT cycle forwards the read data; it is held in d_data_q from then on.
    assign bus.d_data     = d_first_q ? bus.reg_rdata : d_data_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            len_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            s_ready_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            core_clear_q <= 1'b0;
            core_run_q   <= 1'b0;
            raddr_q      <= '0;
            d_valid_q    <= 1'b0;
            d_first_q    <= 1'b0;
            d_idx_q      <= '0;
            d_data_q     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            run_cycles   <= '0;
        end else begin
            d_first_q <= 1'b0;
            if (d_first_q) d_data_q <= bus.reg_rdata;
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (start) begin
                        state_q    <= StInit;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        run_cycles <= '0;
                        len_q      <= len_clamp;
                        tmo_q      <= timeout;
                        cnt_q      <= '0;
                        reg_we_q   <= 1'b1;
                        reg_addr_q <= '0;
                    end
                end
                StInit: begin
                    // Address wraps back to zero after the last register.
                    reg_addr_q <= reg_addr_q + REG_AW'(1);
                    if (reg_addr_q == RegLast) begin
                        reg_we_q <= 1'b0;
                        if (len_q == '0) begin
                            state_q      <= StClear;
                            core_clear_q <= 1'b1;
                        end else begin
                            state_q   <= StLoad;
                            s_ready_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (beat) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            s_ready_q    <= 1'b0;
                            state_q      <= StClear;
                            core_clear_q <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    core_clear_q <= 1'b0;
                    core_run_q   <= 1'b1;
                    state_q      <= StRun;
                end
                StRun: begin
                    run_cycles <= run_inc;
                    // Halt takes priority over a watchdog expiring in the same cycle.
                    if (bus.core_halted) begin
                        core_run_q <= 1'b0;
                        raddr_q    <= '0;
                        state_q    <= StDumpRd;
                    end else if (tmo_q != '0 && run_inc == tmo_q) begin
                        core_run_q <= 1'b0;
                        err        <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= StError;
                    end
                end
                StDumpRd: begin
                    d_valid_q <= 1'b1;
                    d_first_q <= 1'b1;
                    d_idx_q   <= raddr_q;
                    state_q   <= StDumpOut;
                end
                StDumpOut: begin
                    if (bus.d_ready) begin
                        d_valid_q <= 1'b0;
                        if (d_idx_q == DumpLast) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            raddr_q <= raddr_q + REG_AW'(1);
                            state_q <= StDumpRd;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Directed bench for mips_boot_sequencer: scenario table plus reset corner sequences,
// with a small behavioural core, instruction memory and register file.
`timescale 1ns/1ps
module tb_mips_boot_sequencer;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int RW = 5;
    localparam int DN = 6;
    localparam int CW = 16;

    typedef struct {
        int prog_len;
        int tmo;
        bit force_halt;
        bit block_halt;
        bit gap;
        int stall;
        int restart_at;
        int dump_mode;
        bit exp_done;
        bit exp_err;
        int exp_run;
        int exp_dumps;
    } vec_t;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic [CW-1:0] timeout = '0;
    logic          busy, done, err;
    logic [CW-1:0] run_cycles;
    bit            force_halt = 1'b0;
    bit            block_halt = 1'b0;
    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] prog [9];

    mips_boot_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW)) bus ();

    mips_boot_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .DUMP_N(DN), .CNT_W(CW)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .prog_len(prog_len), .timeout(timeout),
        .bus(bus), .busy(busy), .done(done), .err(err), .run_cycles(run_cycles)
    );

    always #5 clk1 = ~clk1;

    // Behavioural core with instruction memory and synchronous-read register file.
    logic [DW-1:0] imem [1 << AW];
    logic [DW-1:0] rf [1 << RW];
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] pc;
    logic          halted_q;
    wire  [DW-1:0] ir  = imem[pc];
    wire  [5:0]    op  = ir[31:26];
    wire  [4:0]    rs  = ir[25:21];
    wire  [4:0]    rt  = ir[20:16];
    wire  [4:0]    rd  = ir[15:11];
    wire  [DW-1:0] imm = {{16{ir[15]}}, ir[15:0]};

    assign bus.reg_rdata   = rdata_q;
    assign bus.core_halted = force_halt | (halted_q & ~block_halt);

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            pc       <= '0;
            halted_q <= 1'b0;
        end else begin
            if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.reg_we) rf[bus.reg_addr] <= bus.reg_wdata;
            rdata_q <= rf[bus.reg_raddr];
            if (bus.core_clear) begin
                pc       <= '0;
                halted_q <= 1'b0;
            end else if (bus.core_run && !halted_q && !force_halt) begin
                pc <= pc + 1'b1;
                case (op)
                    6'h00:   rf[rd] <= rf[rs] + rf[rt];
                    6'h01:   rf[rd] <= rf[rs] - rf[rt];
                    6'h02:   rf[rd] <= rf[rs] & rf[rt];
                    6'h03:   rf[rd] <= rf[rs] | rf[rt];
                    6'h0a:   rf[rt] <= rf[rs] + imm;
                    6'h3f:   halted_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int idx);
        if (idx < 9) return prog[idx];
        return 32'ha500_0000 | DW'(idx);
    endfunction

    function automatic logic [DW-1:0] exp_dump(input int mode, input int i);
        if (mode == 1) return DW'(i);
        case (i)
            0:       return 32'd0;
            1:       return 32'd10;
            2:       return 32'd20;
            3:       return 32'd25;
            4:       return 32'd30;
            default: return 32'd55;
        endcase
    endfunction

    task automatic run_vec(input int n, input vec_t v);
        int beats = 0, dumps = 0, runs = 0, wes = 0, clears = 0, stall = 0;
        int first_we = -1, first_addr = -1, exp_beats;
        bit unstable = 1'b0, multi = 1'b0, finished = 1'b0;
        logic [RW-1:0] hold_idx = '0;
        logic [DW-1:0] hold_data = '0;
        exp_beats  = (v.prog_len > (1 << AW)) ? (1 << AW) : v.prog_len;
        force_halt = v.force_halt;
        block_halt = v.block_halt;
        @(negedge clk1);
        prog_len = (AW + 1)'(v.prog_len);
        timeout  = CW'(v.tmo);
        start    = 1'b1;
        for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
            @(negedge clk1);
            start         = (v.restart_at != 0 && runs == v.restart_at);
            bus.s_valid   = v.gap ? ((cyc % 2) == 1) : 1'b1;
            bus.s_data    = word(beats);
            bus.d_ready   = (stall >= v.stall);
            #4;
            if (int'(bus.mem_we) + int'(bus.reg_we) + int'(bus.core_clear)
                + int'(bus.core_run) > 1) multi = 1'b1;
            if (bus.reg_we) begin
                wes++;
                if (first_we < 0) begin
                    first_we   = cyc;
                    first_addr = int'(bus.reg_addr);
                end
            end
            if (bus.core_clear) clears++;
            if (bus.core_run) runs++;
            if (bus.s_valid && bus.s_ready) beats++;
            if (bus.d_valid) begin
                if (stall == 0) begin
                    hold_idx  = bus.d_idx;
                    hold_data = bus.d_data;
                end else if (bus.d_idx !== hold_idx || bus.d_data !== hold_data) begin
                    unstable = 1'b1;
                end
                if (bus.d_ready) begin
                    check($sformatf("v%0d dump%0d d_idx", n, dumps), 64'(bus.d_idx), 64'(dumps));
                    check($sformatf("v%0d dump%0d d_data", n, dumps), 64'(bus.d_data),
                          64'(exp_dump(v.dump_mode, dumps)));
                    dumps++;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
            if (done || err) finished = 1'b1;
        end
        start = 1'b0;
        check($sformatf("v%0d finished in budget", n), 64'(finished), 64'd1);
        check($sformatf("v%0d done", n), 64'(done), 64'(v.exp_done));
        check($sformatf("v%0d err", n), 64'(err), 64'(v.exp_err));
        check($sformatf("v%0d busy", n), 64'(busy), 64'd0);
        check($sformatf("v%0d run_cycles", n), 64'(run_cycles), 64'(v.exp_run));
        check($sformatf("v%0d core_run cycles", n), 64'(runs), 64'(v.exp_run));
        check($sformatf("v%0d dumps", n), 64'(dumps), 64'(v.exp_dumps));
        check($sformatf("v%0d beats", n), 64'(beats), 64'(exp_beats));
        check($sformatf("v%0d reg_we cycles", n), 64'(wes), 64'(1 << RW));
        check($sformatf("v%0d first reg_we cycle", n), 64'(first_we), 64'd1);
        check($sformatf("v%0d first reg_addr", n), 64'(first_addr), 64'd0);
        check($sformatf("v%0d core_clear cycles", n), 64'(clears), 64'd1);
        check($sformatf("v%0d d_data stable", n), 64'(unstable), 64'd0);
        check($sformatf("v%0d exclusive enables", n), 64'(multi), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy/done/err"}, 64'({busy, done, err}), 64'd0);
        check({tag, " run_cycles"}, 64'(run_cycles), 64'd0);
        check({tag, " s_ready/d_valid"}, 64'({bus.s_ready, bus.d_valid}), 64'd0);
        check({tag, " enables"},
              64'({bus.mem_we, bus.reg_we, bus.core_clear, bus.core_run}), 64'd0);
        check({tag, " addresses"}, 64'({bus.mem_addr, bus.reg_addr, bus.reg_raddr, bus.d_idx}),
              64'd0);
        check({tag, " d_data"}, 64'(bus.d_data), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int   beats;
        prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
        prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
        prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
        // prog_len, tmo, force_halt, block_halt, gap, stall, restart_at, dump_mode,
        // exp_done, exp_err, exp_run, exp_dumps
        vecs[0] = '{9,    0,  0, 0, 0, 0, 0, 0, 1, 0, 10, 6};
        vecs[1] = '{9,    0,  0, 0, 1, 4, 0, 0, 1, 0, 10, 6};
        vecs[2] = '{0,    0,  1, 0, 0, 0, 0, 1, 1, 0, 1,  6};
        vecs[3] = '{9,    20, 0, 1, 0, 0, 0, 0, 0, 1, 20, 0};
        vecs[4] = '{9,    10, 0, 0, 0, 0, 0, 0, 1, 0, 10, 6};
        vecs[5] = '{9,    9,  0, 0, 0, 0, 0, 0, 0, 1, 9,  0};
        vecs[6] = '{9,    30, 0, 1, 0, 0, 5, 0, 0, 1, 30, 0};
        vecs[7] = '{1029, 0,  0, 0, 0, 0, 0, 0, 1, 0, 10, 6};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.d_ready = 1'b0;
        #12;
        check_quiet("in reset");
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        check_quiet("idle after reset");

        // Reset in the middle of LOAD, three words in.
        prog_len    = 11'd9;
        timeout     = '0;
        start       = 1'b1;
        bus.s_valid = 1'b1;
        beats       = 0;
        @(negedge clk1);
        start = 1'b0;
        for (int c = 0; c < 200 && beats < 3; c++) begin
            @(negedge clk1);
            bus.s_data = word(beats);
            #4;
            if (bus.s_ready) beats++;
        end
        check("midload beats", 64'(beats), 64'd3);
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        check_quiet("midload reset");
        check("midload word2 kept", 64'(imem[2]), 64'(prog[2]));
        bus.s_valid = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            if (i <= 1 || i == 7) begin
                for (int w = 0; w < 9; w++)
                    check($sformatf("v%0d imem[%0d]", i, w), 64'(imem[w]), 64'(prog[w]));
            end
            if (i == 7) check("v7 imem[1023]", 64'(imem[1023]), 64'(word(1023)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_boot_sequencer.md
# mips_boot_sequencer

Parametrised, synthesizable successor to the bench-driven bring-up of the MIPS_32 core: initialises the register file, streams a program image into instruction memory, clears and releases the core, watches for HALTED, and streams out a configurable register dump. Sits between a host/debug stream interface and the core's memory, register-file and control ports. Adds a run-cycle counter and a watchdog timeout, which the bench-driven bring-up does not have.

## Interface
- DATA_W, 32, memory/register word width
- ADDR_W, 10, instruction-memory address width
- REG_AW, 5, register-file address width (2^REG_AW registers)
- DUMP_N, 6, registers dumped after halt, R0..R(DUMP_N-1), 1..2^REG_AW
- CNT_W, 16, run-cycle counter and timeout width
- clk1  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a sequence from IDLE/DONE/ERROR
- prog_len  in  ADDR_W+1  words to load; sampled at start
- timeout  in  CNT_W  max run cycles; 0 = no watchdog; sampled at start
- s_valid / s_ready  in / out  1  program-word stream handshake
- s_data  in  DATA_W  program word
- mem_we, mem_addr, mem_wdata  out  1, ADDR_W, DATA_W  instruction-memory write port
- reg_we, reg_addr, reg_wdata  out  1, REG_AW, DATA_W  register-file write port
- reg_raddr  out  REG_AW  register-file read address; reg_rdata valid next cycle
- reg_rdata  in  DATA_W  register read data
- core_clear  out  1  one-cycle pulse: core forces PC=0, HALTED=0, TAKEN_BRANCH=0
- core_run  out  1  core clock-enable
- core_halted  in  1  core HALTED flag
- d_valid / d_ready  out / in  1  dump stream handshake
- d_idx, d_data  out  REG_AW, DATA_W  dumped register index and value
- busy, done, err  out  1  status; done/err are sticky until next start
- run_cycles  out  CNT_W  core_run cycles of last run, saturating

## Operation
- States: IDLE, INIT, LOAD, CLEAR, RUN, DUMP_RD, DUMP_OUT, DONE, ERROR.
- IDLE/DONE/ERROR + start: clear done, err and run_cycles; latch prog_len (clamped to 2^ADDR_W) and timeout; go to INIT.
- INIT: one write per cycle, reg_addr=k, reg_wdata=k (zero-extended), k=0..2^REG_AW-1; then LOAD.
- LOAD: s_ready=1; each s_valid&&s_ready beat writes mem_wdata=s_data at mem_addr=word index (0-based) the same cycle. After prog_len beats, go to CLEAR. prog_len=0: go straight to CLEAR.
- CLEAR: core_clear=1 for exactly one cycle; then RUN.
- RUN: core_run=1; run_cycles increments (saturates at all-ones). core_halted=1 → DUMP_RD, with core_run low from that cycle. timeout≠0 and run_cycles reaching timeout → ERROR (err=1, core_run low).
- DUMP_RD: drive reg_raddr=i; next cycle capture reg_rdata into d_data, d_idx=i, go to DUMP_OUT.
- DUMP_OUT: d_valid=1; d_idx/d_data held stable until d_ready. On handshake: i+1 < DUMP_N → DUMP_RD, else DONE (done=1).
- busy=1 in every state except IDLE, DONE, ERROR. start while busy is ignored.
- Only one of mem_we/reg_we/core_clear/core_run is ever high in a given cycle.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, including s_ready, d_valid, core_run, core_clear, busy, done, err, run_cycles.
- Reset mid-sequence: core_run and write enables drop immediately (asynchronously); partially loaded memory is not restored.
- start → first reg_we: 1 cycle. INIT lasts exactly 2^REG_AW cycles.
- LOAD throughput: 1 word/cycle with s_valid held high.
- core_halted is ignored in CLEAR; it is sampled only while in RUN.
- Per dumped register: 2 cycles minimum (DUMP_RD + DUMP_OUT with d_ready=1).
- Halt and timeout reached in the same cycle: halt wins, giving DUMP then done.

## Test plan
- Reset mid-LOAD (after 3 beats) → next cycle all outputs 0, state IDLE; a fresh start reruns INIT from k=0.
- 9-word program (2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000) with behavioural core model, DUMP_N=6 → dump 0,10,20,25,30,55 with d_idx 0..5; done=1, err=0.
- Backpressure: s_valid toggling every other cycle and d_ready low for 4 cycles per beat → memory contents identical, no d_data change while d_valid && !d_ready.
- prog_len=0 with core_halted tied high → INIT, CLEAR, 1 RUN cycle, then dump; run_cycles=1.
- timeout=20 with core never halting → err=1 after exactly 20 core_run cycles, run_cycles=20, no d_valid.
- start pulsed during RUN → ignored; prog_len=2^ADDR_W+5 → exactly 2^ADDR_W beats accepted.
